// File: rtl/led_sequencer_pkg.sv
// Shared types and constants for the RGB LED step sequencer.
package led_pkg;

    localparam int unsigned TICK_DIV_DEFAULT = 48000;
    localparam int unsigned PWM_BITS_DEFAULT = 8;

    // cfg_data field positions
    localparam int unsigned CFG_FIELD_W = 8;
    localparam int unsigned CFG_R_LSB   = 24;
    localparam int unsigned CFG_G_LSB   = 16;
    localparam int unsigned CFG_B_LSB   = 8;
    localparam int unsigned CFG_DUR_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] dur;
    } step_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        NEXT = 2'd3
    } seq_state_t;

    function automatic step_t unpack_cfg(input logic [31:0] d);
        step_t s;
        s.r   = d[CFG_R_LSB   +: CFG_FIELD_W];
        s.g   = d[CFG_G_LSB   +: CFG_FIELD_W];
        s.b   = d[CFG_B_LSB   +: CFG_FIELD_W];
        s.dur = d[CFG_DUR_LSB +: CFG_FIELD_W];
        return s;
    endfunction

endpackage

// File: rtl/led_sequencer_pwm_ch.sv
// One PWM channel: compares a level against the shared counter and registers the pin.
module led_pwm_ch #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PWM_BITS-1:0] level,
    input  logic [PWM_BITS-1:0] cnt,
    output logic                led
);

    always_ff @(posedge clk) begin
        if (rst) led <= 1'b0;
        else     led <= en && (level > cnt);
    end

endmodule

// File: rtl/led_sequencer.sv
// Programmable RGB LED step sequencer with per-channel PWM dimming.
// Optional feature macro LED_SEQ_BREATHE_EN: triangle envelope scales each step's levels.
module led_sequencer
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int unsigned PWM_BITS  = PWM_BITS_DEFAULT,
    parameter int unsigned NUM_STEPS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         loop,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
    input  logic [31:0]                  cfg_data,
    output logic                         led_r,
    output logic                         led_g,
    output logic                         led_b,
    output logic                         busy,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         done
);

    localparam int unsigned AW = $clog2(NUM_STEPS);
    localparam int unsigned TW = $clog2(TICK_DIV);

    seq_state_t          state;
    logic                loop_q;
    step_t               step_tbl [NUM_STEPS];
    step_t               work;
    logic [TW-1:0]       tick_cnt;
    logic [7:0]          dur_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic                tick_last;
    logic                dur_last;
    logic                run_end;
    logic                pwm_en;
    logic [PWM_BITS-1:0] lvl_r;
    logic [PWM_BITS-1:0] lvl_g;
    logic [PWM_BITS-1:0] lvl_b;

    assign tick_last = (tick_cnt == TW'(TICK_DIV - 1));
    assign dur_last  = (dur_cnt == work.dur - 8'd1);
    assign run_end   = (state == RUN) && tick_last && dur_last;
    // LED registers only load while RUN continues, so pins are dark in LOAD, NEXT and after stop
    assign pwm_en    = (state == RUN) && !stop && !run_end;
    assign busy      = (state != IDLE);

`ifdef LED_SEQ_BREATHE_EN
    localparam int unsigned PW2 = PWM_BITS + 8;

    logic [16:0] ramp;
    logic [7:0]  env;

    // Triangle envelope: ramp 0..510 over the step, folded back down past 255
    always_comb begin
        ramp = '0;
        if (work.dur != 8'd0) ramp = (17'(dur_cnt) * 17'd510) / 17'(work.dur);
        if (ramp > 17'd510) ramp = 17'd510;
        if (work.dur == 8'd1)      env = 8'hFF;
        else if (ramp > 17'd255)   env = 8'(17'd510 - ramp);
        else                       env = 8'(ramp);
    end

    function automatic logic [PWM_BITS-1:0] scale(input logic [PWM_BITS-1:0] lvl,
                                                  input logic [7:0] e);
        logic [PW2-1:0] prod;
        prod = PW2'(lvl) * PW2'(e);
        return PWM_BITS'(prod >> PWM_BITS);
    endfunction

    assign lvl_r = scale(PWM_BITS'(work.r), env);
    assign lvl_g = scale(PWM_BITS'(work.g), env);
    assign lvl_b = scale(PWM_BITS'(work.b), env);
`else
    assign lvl_r = PWM_BITS'(work.r);
    assign lvl_g = PWM_BITS'(work.g);
    assign lvl_b = PWM_BITS'(work.b);
`endif

    // Sequencer FSM, step table and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            loop_q   <= 1'b0;
            step_idx <= '0;
            done     <= 1'b0;
            step_tbl <= '{default: '0};
            work     <= '0;
            tick_cnt <= '0;
            dur_cnt  <= '0;
            pwm_cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (cfg_we) step_tbl[cfg_addr] <= unpack_cfg(cfg_data);

            if (stop) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LOAD;
                            step_idx <= '0;
                            loop_q   <= loop;
                        end
                    end
                    LOAD: begin
                        work     <= step_tbl[step_idx];
                        tick_cnt <= '0;
                        dur_cnt  <= '0;
                        pwm_cnt  <= '0;
                        state    <= (step_tbl[step_idx].dur == 8'd0) ? NEXT : RUN;
                    end
                    RUN: begin
                        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
                        if (tick_last) begin
                            tick_cnt <= '0;
                            dur_cnt  <= dur_cnt + 8'd1;
                            if (dur_last) state <= NEXT;
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    NEXT: begin
                        if (step_idx == AW'(NUM_STEPS - 1)) begin
                            if (loop_q) begin
                                step_idx <= '0;
                                state    <= LOAD;
                            end else begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end else begin
                            step_idx <= step_idx + AW'(1);
                            state    <= LOAD;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_r (
        .clk(clk), .rst(rst), .en(pwm_en), .level(lvl_r), .cnt(pwm_cnt), .led(led_r)
    );
    led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_g (
        .clk(clk), .rst(rst), .en(pwm_en), .level(lvl_g), .cnt(pwm_cnt), .led(led_g)
    );
    led_pwm_ch #(.PWM_BITS(PWM_BITS)) u_ch_b (
        .clk(clk), .rst(rst), .en(pwm_en), .level(lvl_b), .cnt(pwm_cnt), .led(led_b)
    );

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: per-sequence LED/done/cycle totals and step_idx trace.
module tb_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loop;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        led_r;
    logic        led_g;
    logic        led_b;
    logic        busy;
    logic [1:0]  step_idx;
    logic        done;

    led_sequencer #(.TICK_DIV(4), .PWM_BITS(8), .NUM_STEPS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .led_r(led_r), .led_g(led_g), .led_b(led_b),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    cycles;
        int    r;
        int    g;
        int    b;
        int    dn;
    } win_t;

    win_t exp_win[$];
    int   exp_idx[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;

    int   m_cyc, m_r, m_g, m_b, m_dn, m_stray;
    logic m_pb;
    logic [1:0] m_pidx;
    win_t m_w;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void push_win(input string name, input int c, input int r,
                                     input int g, input int b, input int dn);
        win_t w;
        w.name = name; w.cycles = c; w.r = r; w.g = g; w.b = b; w.dn = dn;
        exp_win.push_back(w);
    endfunction

    function automatic void push_oneshot_idx();
        for (int i = 0; i < 4; i++) exp_idx.push_back(i);
    endfunction

    task automatic do_start(input logic lp);
        @(negedge clk);
        start = 1'b1;
        loop  = lp;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        @(negedge clk);
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("busy_after_wait", int'(busy), 0);
    endtask

    // Monitor: totals each busy window and traces step_idx changes against the queues
    initial begin
        wait (mon_en);
        m_cyc = 0; m_r = 0; m_g = 0; m_b = 0; m_dn = 0; m_stray = 0;
        m_pb = 1'b0;
        m_pidx = step_idx;
        forever begin
            @(negedge clk);
            if (busy) begin
                m_cyc++;
                m_r  += int'(led_r);
                m_g  += int'(led_g);
                m_b  += int'(led_b);
                m_dn += int'(done);
            end else if (m_pb) begin
                m_dn += int'(done);
                if (exp_win.size() == 0) begin
                    check("unexpected_window", m_cyc, 0);
                end else begin
                    m_w = exp_win.pop_front();
                    check({m_w.name, "_cycles"}, m_cyc, m_w.cycles);
                    check({m_w.name, "_red_high"}, m_r, m_w.r);
                    check({m_w.name, "_green_high"}, m_g, m_w.g);
                    check({m_w.name, "_blue_high"}, m_b, m_w.b);
                    check({m_w.name, "_done_pulses"}, m_dn, m_w.dn);
                end
                m_cyc = 0; m_r = 0; m_g = 0; m_b = 0; m_dn = 0;
            end else begin
                m_stray += int'(led_r | led_g | led_b | done);
            end
            if (step_idx != m_pidx) begin
                if (exp_idx.size() == 0) check("unexpected_step_idx", int'(step_idx), -1);
                else check("step_idx_trace", int'(step_idx), exp_idx.pop_front());
                m_pidx = step_idx;
            end
            m_pb = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        check("reset_led_r", int'(led_r), 0);
        check("reset_led_g", int'(led_g), 0);
        check("reset_led_b", int'(led_b), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step_idx", int'(step_idx), 0);
        check("reset_done", int'(done), 0);
        mon_en = 1'b1;

        // Cleared table: four LOAD/NEXT pairs then done
        push_win("zero_table", 8, 0, 0, 0, 1);
        exp_idx.push_back(1); exp_idx.push_back(2); exp_idx.push_back(3);
        do_start(1'b0);
        wait_idle(100);

        // Full red for two ticks
        cfg_write(2'd0, 32'hFF00_0002);
        cfg_write(2'd1, 32'h0000_0000);
        cfg_write(2'd2, 32'h0000_0000);
        cfg_write(2'd3, 32'h0000_0000);
        push_win("red_full", 16, 7, 0, 0, 1);
        push_oneshot_idx();
        do_start(1'b0);
        wait_idle(100);

        // Green and blue partial levels on step 1
        cfg_write(2'd0, 32'h0000_0000);
        cfg_write(2'd1, 32'h0010_0302);
        push_win("green_blue", 16, 0, 7, 3, 1);
        push_oneshot_idx();
        do_start(1'b0);
        wait_idle(100);

        // Half duty over one full PWM period
        cfg_write(2'd0, 32'h8000_0040);
        cfg_write(2'd1, 32'h0000_0000);
        push_win("red_half", 264, 128, 0, 0, 1);
        push_oneshot_idx();
        do_start(1'b0);
        wait_idle(400);

        // Looping 1-tick steps, stopped in step 1 RUN of the second pass
        cfg_write(2'd0, 32'h0300_0001);
        cfg_write(2'd1, 32'h0003_0001);
        cfg_write(2'd2, 32'h0000_0301);
        cfg_write(2'd3, 32'h0101_0101);
        push_win("loop_stop", 33, 7, 5, 4, 0);
        push_oneshot_idx();
        exp_idx.push_back(0); exp_idx.push_back(1);
        do_start(1'b1);
        repeat (32) @(posedge clk);
        do_stop();
        wait_idle(10);

        // start and stop together from IDLE
        @(negedge clk);
        start = 1'b1; stop = 1'b1; loop = 1'b0;
        @(posedge clk);
        #1 start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        check("start_stop_same_cycle_busy", int'(busy), 0);
        check("start_stop_same_cycle_idx", int'(step_idx), 1);

        // Second start while busy is ignored
        push_win("start_while_busy", 24, 4, 4, 4, 1);
        push_oneshot_idx();
        do_start(1'b0);
        repeat (8) @(posedge clk);
        do_start(1'b0);
        wait_idle(100);

        // Table writes during step 1: step 2 picks up the new value, step 1 keeps running as loaded
        cfg_write(2'd0, 32'h0000_0001);
        cfg_write(2'd1, 32'h0040_0002);
        cfg_write(2'd2, 32'h0000_0001);
        cfg_write(2'd3, 32'h0000_0000);
        push_win("cfg_live_write", 24, 3, 7, 0, 1);
        push_oneshot_idx();
        do_start(1'b0);
        repeat (9) @(posedge clk);
        cfg_write(2'd1, 32'h0000_0002);
        cfg_write(2'd2, 32'hFF00_0001);
        wait_idle(100);

        push_win("cfg_after_write", 24, 3, 0, 0, 1);
        push_oneshot_idx();
        do_start(1'b0);
        wait_idle(100);

        repeat (3) @(negedge clk);
        check("leds_or_done_while_idle", m_stray, 0);
        check("windows_left", exp_win.size(), 0);
        check("idx_left", exp_idx.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
